// File: rtl/snitch_ipu_share_pkg.sv
// Shared types and helpers for snitch_ipu_share.
package snitch_ipu_share_pkg;

  // Upper bound on the shared ID width carried inside the internal structs.
  localparam int unsigned IdMaxW = 16;

  typedef struct packed {
    logic [31:0]       addr;
    logic [IdMaxW-1:0] id;
    logic [31:0]       op;
    logic [31:0]       arga;
    logic [31:0]       argb;
    logic [31:0]       argc;
  } ipu_share_req_t;

  typedef struct packed {
    logic [31:0]       data;
    logic [IdMaxW-1:0] id;
    logic              error;
  } ipu_share_resp_t;

  // Width of the IPU-side ID: core-side ID plus the core index tag.
  function automatic int unsigned share_id_width(int unsigned id_width, int unsigned num_cores);
    return id_width + $clog2(num_cores);
  endfunction

endpackage

// File: rtl/snitch_ipu_share_rr_arb.sv
// Round-robin arbiter with grant lock: holds the grant while the consumer stalls.
module snitch_ipu_share_rr_arb #(
  parameter int unsigned  NumReq = 4,
  localparam int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] elig_i,
  input  logic              ready_i,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic              gnt_valid_o,
  output logic              lock_o
);

  logic [IdxW-1:0] rr_q, rr_d, gidx_q, gidx_d, cand, search_idx;
  logic            lock_q, lock_d, search_found;

  // First eligible requester at or after the pointer, wrapping around.
  always_comb begin
    search_idx   = rr_q;
    search_found = 1'b0;
    cand         = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      cand = IdxW'((32'(rr_q) + off) % NumReq);
      if (!search_found && elig_i[cand]) begin
        search_found = 1'b1;
        search_idx   = cand;
      end
    end
  end

  // A locked grant overrides the search until the consumer accepts.
  always_comb begin
    gnt_idx_o   = lock_q ? gidx_q : search_idx;
    gnt_valid_o = lock_q ? elig_i[gidx_q] : search_found;
    lock_d      = gnt_valid_o && !ready_i;
    gidx_d      = gnt_idx_o;
    rr_d        = rr_q;
    if (gnt_valid_o && ready_i) rr_d = IdxW'((32'(gnt_idx_o) + 1) % NumReq);
  end

  assign lock_o = lock_q;

  // Pointer, lock flag and frozen grant index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q   <= '0;
      gidx_q <= '0;
      lock_q <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      gidx_q <= gidx_d;
      lock_q <= lock_d;
    end
  end

endmodule

// File: rtl/snitch_ipu_share.sv
// Shares one IPU between NumCores cores: round-robin request mux, one-entry
// response register, per-core outstanding caps. Optional statistics counters
// are enabled with SNITCH_IPU_SHARE_STATS_EN.
module snitch_ipu_share
  import snitch_ipu_share_pkg::*;
#(
  parameter int unsigned  NumCores       = 4,
  parameter int unsigned  IdWidth        = 5,
  parameter int unsigned  MaxOutstanding = 4,
  localparam int unsigned CoreIdxW       = $clog2(NumCores),
  localparam int unsigned ShareIdW       = share_id_width(IdWidth, NumCores)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumCores-1:0][31:0]         core_qaddr_i,
  input  logic [NumCores-1:0][IdWidth-1:0]  core_qid_i,
  input  logic [NumCores-1:0][31:0]         core_qdata_op_i,
  input  logic [NumCores-1:0][31:0]         core_qdata_arga_i,
  input  logic [NumCores-1:0][31:0]         core_qdata_argb_i,
  input  logic [NumCores-1:0][31:0]         core_qdata_argc_i,
  input  logic [NumCores-1:0]               core_qvalid_i,
  output logic [NumCores-1:0]               core_qready_o,
  output logic [NumCores-1:0][31:0]         core_pdata_o,
  output logic [NumCores-1:0][IdWidth-1:0]  core_pid_o,
  output logic [NumCores-1:0]               core_perror_o,
  output logic [NumCores-1:0]               core_pvalid_o,
  input  logic [NumCores-1:0]               core_pready_i,
  output logic [31:0]                       ipu_qaddr_o,
  output logic [31:0]                       ipu_qdata_op_o,
  output logic [31:0]                       ipu_qdata_arga_o,
  output logic [31:0]                       ipu_qdata_argb_o,
  output logic [31:0]                       ipu_qdata_argc_o,
  output logic [ShareIdW-1:0]               ipu_qid_o,
  output logic                              ipu_qvalid_o,
  input  logic                              ipu_qready_i,
  input  logic [31:0]                       ipu_pdata_i,
  input  logic [ShareIdW-1:0]               ipu_pid_i,
  input  logic                              ipu_perror_i,
  input  logic                              ipu_pvalid_i,
  output logic                              ipu_pready_o,
  output logic [31:0]                       conflict_cnt_o,
  output logic [31:0]                       stall_cnt_o
);

  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

  logic [NumCores-1:0][OutW-1:0] outst_q, outst_d;
  logic [NumCores-1:0]           elig, req_hs, resp_hs;
  logic [CoreIdxW-1:0]           gnt_idx, tgt_q, tgt_d;
  logic                          gnt_valid, lock;
  logic                          resp_valid_q, resp_valid_d, tgt_ready, tgt_invalid;
  ipu_share_req_t                req_mux;
  ipu_share_resp_t               resp_q, resp_d;
  logic                          unused_id;

  // A core may compete only while it has room for another in-flight request.
  always_comb begin
    for (int unsigned i = 0; i < NumCores; i++) begin
      elig[i] = core_qvalid_i[i] && (outst_q[i] < OutW'(MaxOutstanding));
    end
  end

  snitch_ipu_share_rr_arb #(
    .NumReq (NumCores)
  ) u_rr_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .elig_i      (elig),
    .ready_i     (ipu_qready_i),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid),
    .lock_o      (lock)
  );

  // Request mux and per-core ready.
  always_comb begin
    req_mux      = '0;
    req_mux.addr = core_qaddr_i[gnt_idx];
    req_mux.id   = IdMaxW'({gnt_idx, core_qid_i[gnt_idx]});
    req_mux.op   = core_qdata_op_i[gnt_idx];
    req_mux.arga = core_qdata_arga_i[gnt_idx];
    req_mux.argb = core_qdata_argb_i[gnt_idx];
    req_mux.argc = core_qdata_argc_i[gnt_idx];
    core_qready_o = '0;
    core_qready_o[gnt_idx] = gnt_valid && ipu_qready_i;
  end

  assign ipu_qaddr_o      = req_mux.addr;
  assign ipu_qid_o        = req_mux.id[ShareIdW-1:0];
  assign ipu_qdata_op_o   = req_mux.op;
  assign ipu_qdata_arga_o = req_mux.arga;
  assign ipu_qdata_argb_o = req_mux.argb;
  assign ipu_qdata_argc_o = req_mux.argc;
  assign ipu_qvalid_o     = gnt_valid;

  // Target decode of the held response; out-of-range targets are dropped.
  always_comb begin
    tgt_ready   = 1'b0;
    tgt_invalid = 1'b1;
    for (int unsigned i = 0; i < NumCores; i++) begin
      core_pvalid_o[i] = resp_valid_q && (tgt_q == CoreIdxW'(i));
      if (tgt_q == CoreIdxW'(i)) begin
        tgt_ready   = core_pready_i[i];
        tgt_invalid = 1'b0;
      end
    end
  end

  assign ipu_pready_o  = !resp_valid_q || tgt_ready || tgt_invalid;
  assign core_pdata_o  = {NumCores{resp_q.data}};
  assign core_pid_o    = {NumCores{resp_q.id[IdWidth-1:0]}};
  assign core_perror_o = {NumCores{resp_q.error}};
  assign unused_id     = ^{req_mux.id, resp_q.id};

  // Response register: capture has priority over clear.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_d       = resp_q;
    tgt_d        = tgt_q;
    if (ipu_pvalid_i && ipu_pready_o) begin
      resp_valid_d = 1'b1;
      resp_d.data  = ipu_pdata_i;
      resp_d.id    = IdMaxW'(ipu_pid_i[IdWidth-1:0]);
      resp_d.error = ipu_perror_i;
      tgt_d        = ipu_pid_i[IdWidth +: CoreIdxW];
    end else if (resp_valid_q && (tgt_ready || tgt_invalid)) begin
      resp_valid_d = 1'b0;
    end
  end

  // Outstanding counters; simultaneous issue and return cancel out.
  always_comb begin
    for (int unsigned i = 0; i < NumCores; i++) begin
      req_hs[i]  = gnt_valid && ipu_qready_i && (gnt_idx == CoreIdxW'(i));
      resp_hs[i] = core_pvalid_o[i] && core_pready_i[i];
      outst_d[i] = outst_q[i];
      if (req_hs[i] && !resp_hs[i]) outst_d[i] = outst_q[i] + OutW'(1);
      else if (!req_hs[i] && resp_hs[i]) outst_d[i] = outst_q[i] - OutW'(1);
    end
  end

  // Response and outstanding state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
      tgt_q        <= '0;
      outst_q      <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
      tgt_q        <= tgt_d;
      outst_q      <= outst_d;
    end
  end

`ifdef SNITCH_IPU_SHARE_STATS_EN
  logic [31:0] conflict_q, conflict_d, stall_q, stall_d;
  logic        multi_elig;

  // Two or more bits set iff clearing the lowest set bit leaves something.
  always_comb begin
    multi_elig = |(elig & (elig - NumCores'(1)));
    conflict_d = conflict_q;
    stall_d    = stall_q;
    if (multi_elig && !(&conflict_q)) conflict_d = conflict_q + 32'd1;
    if (gnt_valid && !ipu_qready_i && !(&stall_q)) stall_d = stall_q + 32'd1;
  end

  // Saturating statistics counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_q <= '0;
      stall_q    <= '0;
    end else begin
      conflict_q <= conflict_d;
      stall_q    <= stall_d;
    end
  end

  assign conflict_cnt_o = conflict_q;
  assign stall_cnt_o    = stall_q;
`else
  assign conflict_cnt_o = '0;
  assign stall_cnt_o    = '0;
`endif

  // A locked requester must hold its request until accepted.
  assert property (@(posedge clk_i) disable iff (!rst_ni) lock |-> core_qvalid_i[gnt_idx]);
  // Responses must only target existing cores.
  assert property (@(posedge clk_i) disable iff (!rst_ni) resp_valid_q |-> int'(tgt_q) < NumCores);

  for (genvar i = 0; i < NumCores; i++) begin : g_outst_chk
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     !(resp_hs[i] && !req_hs[i] && outst_q[i] == '0));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     !(req_hs[i] && !resp_hs[i] && outst_q[i] == OutW'(MaxOutstanding)));
  end

endmodule

// File: tb/tb_snitch_ipu_share.sv
// Directed self-checking bench for snitch_ipu_share (NumCores=4, MaxOutstanding=2).
module tb_snitch_ipu_share;

  localparam int unsigned NumCores = 4;
  localparam int unsigned IdWidth  = 5;
  localparam int unsigned MaxOut   = 2;
  localparam int unsigned ShareW   = 7;
`ifdef SNITCH_IPU_SHARE_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_ni;
  logic [NumCores-1:0][31:0]        core_qaddr, core_op, core_arga, core_argb, core_argc;
  logic [NumCores-1:0][IdWidth-1:0] core_qid;
  logic [NumCores-1:0]              core_qvalid, core_qready, core_perror, core_pvalid;
  logic [NumCores-1:0]              core_pready;
  logic [NumCores-1:0][31:0]        core_pdata;
  logic [NumCores-1:0][IdWidth-1:0] core_pid;
  logic [31:0]        ipu_qaddr, ipu_op, ipu_arga, ipu_argb, ipu_argc, ipu_pdata;
  logic [ShareW-1:0]  ipu_qid, ipu_pid;
  logic               ipu_qvalid, ipu_qready, ipu_perror, ipu_pvalid, ipu_pready;
  logic [31:0]        conflict_cnt, stall_cnt;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned fails  = 0;

  always #5 clk = ~clk;

  snitch_ipu_share #(
    .NumCores       (NumCores),
    .IdWidth        (IdWidth),
    .MaxOutstanding (MaxOut)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .core_qaddr_i      (core_qaddr),
    .core_qid_i        (core_qid),
    .core_qdata_op_i   (core_op),
    .core_qdata_arga_i (core_arga),
    .core_qdata_argb_i (core_argb),
    .core_qdata_argc_i (core_argc),
    .core_qvalid_i     (core_qvalid),
    .core_qready_o     (core_qready),
    .core_pdata_o      (core_pdata),
    .core_pid_o        (core_pid),
    .core_perror_o     (core_perror),
    .core_pvalid_o     (core_pvalid),
    .core_pready_i     (core_pready),
    .ipu_qaddr_o       (ipu_qaddr),
    .ipu_qdata_op_o    (ipu_op),
    .ipu_qdata_arga_o  (ipu_arga),
    .ipu_qdata_argb_o  (ipu_argb),
    .ipu_qdata_argc_o  (ipu_argc),
    .ipu_qid_o         (ipu_qid),
    .ipu_qvalid_o      (ipu_qvalid),
    .ipu_qready_i      (ipu_qready),
    .ipu_pdata_i       (ipu_pdata),
    .ipu_pid_i         (ipu_pid),
    .ipu_perror_i      (ipu_perror),
    .ipu_pvalid_i      (ipu_pvalid),
    .ipu_pready_o      (ipu_pready),
    .conflict_cnt_o    (conflict_cnt),
    .stall_cnt_o       (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    core_qvalid = '0;
    core_pready = '1;
    ipu_qready  = 1'b1;
    ipu_pvalid  = 1'b0;
    ipu_pid     = '0;
    ipu_pdata   = '0;
    ipu_perror  = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    core_qaddr = '0; core_op = '0; core_arga = '0; core_argb = '0; core_argc = '0;
    core_qid   = '0;
    do_reset();
    #1;
    check("rst_pvalid", 32'(core_pvalid), 32'h0);
    check("rst_pready", 32'(ipu_pready), 32'h1);
    check("rst_qvalid", 32'(ipu_qvalid), 32'h0);
    check("rst_conflict", conflict_cnt, 32'h0);
    check("rst_stall", stall_cnt, 32'h0);

    // Single core: core 2, id 5.
    core_qvalid = 4'b0100; core_qid[2] = 5'd5;
    core_qaddr[2] = 32'h2000_0002; core_op[2] = 32'h0000_0011;
    #1;
    check("single_qvalid", 32'(ipu_qvalid), 32'h1);
    check("single_qid", 32'(ipu_qid), 32'h45);
    check("single_qready", 32'(core_qready), 32'h4);
    check("single_addr", ipu_qaddr, 32'h2000_0002);
    check("single_op", ipu_op, 32'h0000_0011);
    tick();
    core_qvalid = '0;
    ipu_pvalid = 1'b1; ipu_pid = 7'h45; ipu_pdata = 32'hDEAD_BEEF; ipu_perror = 1'b1;
    #1;
    check("single_pvalid_early", 32'(core_pvalid), 32'h0);
    check("single_ipu_pready", 32'(ipu_pready), 32'h1);
    tick();
    ipu_pvalid = 1'b0;
    #1;
    check("single_pvalid", 32'(core_pvalid), 32'h4);
    check("single_pid", 32'(core_pid[2]), 32'h5);
    check("single_pdata", core_pdata[1], 32'hDEAD_BEEF);
    check("single_perror", 32'(core_perror), 32'hF);
    tick();
    check("single_drained", 32'(core_pvalid), 32'h0);

    // Fairness: all cores request continuously.
    do_reset();
    for (int i = 0; i < 4; i++) core_qid[i] = 5'(i);
    core_qvalid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("fair_grant", 32'(ipu_qid[6:5]), 32'(k % 4));
      check("fair_qready", 32'(core_qready), 32'(1 << (k % 4)));
      tick();
    end
    core_qvalid = '0;
    #1;
    check("fair_conflict", conflict_cnt, Stats ? 32'd5 : 32'd0);

    // Lock: core 1 granted and stalled while core 0 joins.
    do_reset();
    ipu_qready = 1'b0; core_qvalid = 4'b0010;
    #1;
    check("lock_grant_a", 32'(ipu_qid[6:5]), 32'h1);
    check("lock_qready_a", 32'(core_qready), 32'h0);
    tick();
    core_qvalid = 4'b0011;
    #1;
    check("lock_grant_b", 32'(ipu_qid[6:5]), 32'h1);
    tick();
    #1;
    check("lock_grant_c", 32'(ipu_qid[6:5]), 32'h1);
    tick();
    ipu_qready = 1'b1;
    #1;
    check("lock_qready_d", 32'(core_qready), 32'h2);
    check("lock_stall", stall_cnt, Stats ? 32'd3 : 32'd0);
    tick();
    check("lock_next_grant", 32'(ipu_qid[6:5]), 32'h0);
    check("lock_conflict", conflict_cnt, Stats ? 32'd3 : 32'd0);
    core_qvalid = '0;

    // Outstanding cap: core 3 limited to two in flight.
    do_reset();
    core_qvalid = 4'b1000; core_qid[3] = 5'd7;
    #1;
    check("cap_qready_1", 32'(core_qready), 32'h8);
    tick();
    check("cap_qready_2", 32'(core_qready), 32'h8);
    tick();
    check("cap_withheld", 32'(core_qready), 32'h0);
    check("cap_qvalid", 32'(ipu_qvalid), 32'h0);
    ipu_pvalid = 1'b1; ipu_pid = 7'h67; ipu_pdata = 32'h3333_0000;
    tick();
    ipu_pvalid = 1'b0;
    #1;
    check("cap_resp", 32'(core_pvalid), 32'h8);
    check("cap_still_full", 32'(core_qready), 32'h0);
    tick();
    check("cap_reopen", 32'(core_qready), 32'h8);
    check("cap_reopen_qvalid", 32'(ipu_qvalid), 32'h1);
    tick();
    core_qvalid = '0;

    // Response backpressure on core 0.
    do_reset();
    core_qvalid = 4'b0001; core_qid[0] = 5'd1;
    tick();
    core_qid[0] = 5'd2;
    tick();
    core_qvalid = '0;
    core_pready = 4'b1110;
    ipu_pvalid = 1'b1; ipu_pid = 7'h01; ipu_pdata = 32'h0000_000A; ipu_perror = 1'b0;
    #1;
    check("bp_pready_empty", 32'(ipu_pready), 32'h1);
    tick();
    ipu_pid = 7'h02; ipu_pdata = 32'h0000_000B;
    #1;
    check("bp_pready_held", 32'(ipu_pready), 32'h0);
    check("bp_pvalid", 32'(core_pvalid), 32'h1);
    check("bp_data_a", core_pdata[0], 32'h0000_000A);
    check("bp_pid_a", 32'(core_pid[0]), 32'h1);
    tick();
    check("bp_pready_held2", 32'(ipu_pready), 32'h0);
    check("bp_data_a2", core_pdata[0], 32'h0000_000A);
    core_pready = 4'hF;
    #1;
    check("bp_pready_release", 32'(ipu_pready), 32'h1);
    tick();
    ipu_pvalid = 1'b0;
    #1;
    check("bp_pvalid_b", 32'(core_pvalid), 32'h1);
    check("bp_data_b", core_pdata[0], 32'h0000_000B);
    check("bp_pid_b", 32'(core_pid[0]), 32'h2);
    tick();
    check("bp_drained", 32'(core_pvalid), 32'h0);
    check("bp_pready_idle", 32'(ipu_pready), 32'h1);

    // Reset mid-operation: lock on core 2, response held for core 1.
    do_reset();
    ipu_qready = 1'b0; core_qvalid = 4'b0100; core_pready = '0;
    ipu_pvalid = 1'b1; ipu_pid = 7'h23; ipu_pdata = 32'h1234_5678;
    tick();
    ipu_pvalid = 1'b0;
    #1;
    check("mid_pvalid", 32'(core_pvalid), 32'h2);
    check("mid_pready", 32'(ipu_pready), 32'h0);
    check("mid_stall", stall_cnt, Stats ? 32'd1 : 32'd0);
    core_qvalid = 4'b0110;
    #1;
    check("mid_locked_grant", 32'(ipu_qid[6:5]), 32'h2);
    rst_ni = 1'b0;
    #1;
    check("async_pvalid", 32'(core_pvalid), 32'h0);
    check("async_pready", 32'(ipu_pready), 32'h1);
    check("async_stall", stall_cnt, 32'h0);
    check("async_conflict", conflict_cnt, 32'h0);
    check("async_unlocked_grant", 32'(ipu_qid[6:5]), 32'h1);
    core_qvalid = '0;
    tick();
    rst_ni = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
